// File: rtl/axis_repack_pkg.sv
// Shared types and helpers for the AXI-Stream bit repacker.
// REPACK_PAD_EN adds the PAD state used to zero-fill short frames.
package axis_repack_pkg;

`ifdef REPACK_PAD_EN
  typedef enum logic [1:0] {RUN, FLUSH, PAD} repack_state_t;
`else
  typedef enum logic [1:0] {RUN, FLUSH} repack_state_t;
`endif

  function automatic int repack_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int keep_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/repack_out_reg.sv
// Output holding register: loads a beat when empty or being drained,
// and keeps the beat stable while the consumer stalls.
module repack_out_reg #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [KEEP_W-1:0] ld_keep,
  input  logic              ld_last,
  output logic              ld_rdy,
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic              tlast
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  assign ld_rdy = !vld_q || tready;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    if (ld_en) begin
      vld_d  = 1'b1;
      data_d = ld_data;
      keep_d = ld_keep;
      last_d = ld_last;
    end else if (tready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  assign tvalid = vld_q;
  assign tdata  = data_q;
  assign tkeep  = keep_q;
  assign tlast  = last_q;

endmodule

// File: rtl/axis_frame_repacker.sv
// Packs variable-width input beats into full beats and frames of FRAME_LEN bits.
// Define REPACK_PAD_EN to zero-pad flushed frames to the full FRAME_LEN.
module axis_frame_repacker
  import axis_repack_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 40,
  parameter int KEEP_W    = keep_width(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] input_tdata,
  input  logic [KEEP_W-1:0] input_tkeep,
  input  logic              input_tlast,
  input  logic              input_tvalid,
  output logic              input_tready,
  output logic [DATA_W-1:0] output_tdata,
  output logic [KEEP_W-1:0] output_tkeep,
  output logic              output_tlast,
  output logic              output_tvalid,
  input  logic              output_tready
);

  localparam int ACC_W  = 2 * DATA_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int FCNT_W = $clog2(FRAME_LEN + 1);

  repack_state_t     state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  int   fill_i, rem_i, n_i, keep_i, ecnt, drop, drop_e;
  logic emit, elast, go, ld_rdy, in_fire;
  logic [DATA_W-1:0] ones, in_bits, out_bits;

  assign ones   = '1;
  assign fill_i = int'(fill_q);
  assign rem_i  = FRAME_LEN - int'(fcnt_q);
  assign n_i    = repack_min(DATA_W, rem_i);
  assign keep_i = repack_min(int'(input_tkeep), DATA_W);

  // Room for a full beat is guaranteed whenever fill <= DATA_W.
  assign input_tready = !reset && (state_q == RUN) && (fill_i <= DATA_W);
  assign in_fire      = input_tvalid && input_tready;
  assign in_bits      = input_tdata & (ones >> (DATA_W - keep_i));
  assign out_bits     = acc_q[DATA_W-1:0] & (ones >> (DATA_W - ecnt));
  assign go           = emit && ld_rdy;

  always_comb begin
    emit    = 1'b0;
    elast   = 1'b0;
    ecnt    = 0;
    drop    = 0;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fill_i >= n_i) begin
          emit  = 1'b1;
          ecnt  = n_i;
          drop  = n_i;
          elast = (n_i == rem_i);
        end
        if (in_fire && input_tlast) state_d = FLUSH;
      end
      FLUSH: begin
`ifdef REPACK_PAD_EN
        if (fill_i == 0 && fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          emit  = 1'b1;
          ecnt  = n_i;
          drop  = repack_min(fill_i, n_i);
          elast = (n_i == rem_i);
          if (ld_rdy && fill_i <= n_i) state_d = elast ? RUN : PAD;
        end
`else
        if (fill_i > 0) begin
          emit  = 1'b1;
          ecnt  = repack_min(fill_i, n_i);
          drop  = ecnt;
          elast = (ecnt == rem_i) || (fill_i <= n_i);
        end else if (fcnt_q != '0) begin
          emit  = 1'b1;
          elast = 1'b1;
        end
        // A frame-closing beat with residue left keeps flushing into the next frame.
        if (fill_i == 0 && fcnt_q == '0) state_d = RUN;
        else if (ld_rdy && elast && fill_i == drop) state_d = RUN;
`endif
      end
`ifdef REPACK_PAD_EN
      PAD: begin
        emit  = 1'b1;
        ecnt  = n_i;
        elast = (n_i == rem_i);
        if (ld_rdy && elast) state_d = RUN;
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    drop_e = go ? drop : 0;
    acc_d  = acc_q >> drop_e;
    if (in_fire) acc_d = acc_d | (ACC_W'(in_bits) << (fill_i - drop_e));
    fill_d = FILL_W'(fill_i - drop_e + (in_fire ? keep_i : 0));
    fcnt_d = fcnt_q;
    if (go) fcnt_d = elast ? '0 : FCNT_W'(int'(fcnt_q) + ecnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      fcnt_q  <= fcnt_d;
    end
  end

  repack_out_reg #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_out (
    .clk     (clk),
    .reset   (reset),
    .ld_en   (go),
    .ld_data (out_bits),
    .ld_keep (KEEP_W'(ecnt)),
    .ld_last (elast),
    .ld_rdy  (ld_rdy),
    .tready  (output_tready),
    .tvalid  (output_tvalid),
    .tdata   (output_tdata),
    .tkeep   (output_tkeep),
    .tlast   (output_tlast)
  );

endmodule

// File: tb/tb_axis_frame_repacker.sv
// Directed bench for axis_frame_repacker (DATA_W=16, FRAME_LEN=40); output beats
// are captured by a monitor and compared against hand-computed beats.
module tb_axis_frame_repacker;

  localparam int DW = 16;
  localparam int FL = 40;
  localparam int KW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] input_tdata;
  logic [KW-1:0] input_tkeep;
  logic          input_tlast, input_tvalid, input_tready;
  logic [DW-1:0] output_tdata;
  logic [KW-1:0] output_tkeep;
  logic          output_tlast, output_tvalid, output_tready;

  always #5 clk = ~clk;

  axis_frame_repacker #(.DATA_W(DW), .FRAME_LEN(FL), .KEEP_W(KW)) dut (
    .clk           (clk),
    .reset         (reset),
    .input_tdata   (input_tdata),
    .input_tkeep   (input_tkeep),
    .input_tlast   (input_tlast),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .output_tdata  (output_tdata),
    .output_tkeep  (output_tkeep),
    .output_tlast  (output_tlast),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] q_data[$];
  logic [KW-1:0] q_keep[$];
  logic          q_last[$];

  // A beat transfers at the next rising edge when valid&ready hold at the falling edge.
  always @(negedge clk) begin
    if (!reset && output_tvalid && output_tready) begin
      q_data.push_back(output_tdata);
      q_keep.push_back(output_tkeep);
      q_last.push_back(output_tlast);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    input_tvalid = 1'b0;
    input_tdata  = '0;
    input_tkeep  = '0;
    input_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(output_tvalid), 0);
    chk("rst_tdata",  32'(output_tdata),  0);
    chk("rst_tkeep",  32'(output_tkeep),  0);
    chk("rst_tlast",  32'(output_tlast),  0);
    chk("rst_in_rdy", 32'(input_tready),  0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_rdy_after", 32'(input_tready), 1);
    clear_q();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input int k, input logic l);
    int t;
    t = 0;
    input_tdata  = d;
    input_tkeep  = KW'(k);
    input_tlast  = l;
    input_tvalid = 1'b1;
    @(negedge clk);
    while (!input_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!input_tready) chk("send_timeout", 32'(input_tready), 1);
    @(posedge clk); #1;
    input_tvalid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [DW-1:0] d,
                             input logic [KW-1:0] k, input logic l);
    int t;
    t = 0;
    while (q_data.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q_data.size() == 0) begin
      chk({tag, "_present"}, 32'(q_data.size()), 1);
    end else begin
      chk({tag, "_data"}, 32'(q_data.pop_front()), 32'(d));
      chk({tag, "_keep"}, 32'(q_keep.pop_front()), 32'(k));
      chk({tag, "_last"}, 32'(q_last.pop_front()), 32'(l));
    end
  endtask

  task automatic expect_none(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_extra"}, 32'(q_data.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic bp_watch();
    int t;
    t = 0;
    while (!output_tvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_up", 32'(output_tvalid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(output_tdata), 'h1111);
      chk("bp_hold_keep", 32'(output_tkeep), 16);
      chk("bp_hold_last", 32'(output_tlast), 0);
    end
    chk("bp_in_stall", 32'(input_tready), 0);
    @(posedge clk); #1;
    output_tready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    output_tready = 1'b1;
    do_reset();

    // Continuous full beats; frame boundary splits the third beat.
    send(16'hAAAA, 16, 1'b0);
    send(16'hBBBB, 16, 1'b0);
    send(16'hCCCC, 16, 1'b0);
    send(16'h1234, 16, 1'b0);
    expect_beat("cont0", 16'hAAAA, 16, 1'b0);
    expect_beat("cont1", 16'hBBBB, 16, 1'b0);
    expect_beat("cont2", 16'h00CC, 8, 1'b1);
    expect_beat("cont3", 16'h34CC, 16, 1'b0);
    send(16'h0000, 0, 1'b1);
`ifdef REPACK_PAD_EN
    expect_beat("cont_res", 16'h0012, 16, 1'b0);
    expect_beat("cont_pad", 16'h0000, 8, 1'b1);
`else
    expect_beat("cont_res", 16'h0012, 8, 1'b1);
`endif
    expect_none("cont");
    do_reset();

    // Small beats.
    repeat (8) send(16'h001F, 5, 1'b0);
    expect_beat("small0", 16'hFFFF, 16, 1'b0);
    expect_beat("small1", 16'hFFFF, 16, 1'b0);
    expect_beat("small2", 16'h00FF, 8, 1'b1);
    expect_none("small");
    do_reset();

    // Flush with a partial beat.
    send(16'h1111, 16, 1'b0);
    send(16'h000F, 4, 1'b1);
    expect_beat("flush0", 16'h1111, 16, 1'b0);
`ifdef REPACK_PAD_EN
    expect_beat("flush1", 16'h000F, 16, 1'b0);
    expect_beat("flush2", 16'h0000, 8, 1'b1);
`else
    expect_beat("flush1", 16'h000F, 4, 1'b1);
`endif
    expect_none("flush");
    do_reset();

    // Latency, then terminator beat from an empty tlast beat.
    send(16'h1111, 16, 1'b0);
    chk("lat_early", 32'(output_tvalid), 0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(output_tvalid), 1);
    chk("lat_data", 32'(output_tdata), 'h1111);
    send(16'h0000, 0, 1'b1);
    expect_beat("term0", 16'h1111, 16, 1'b0);
`ifdef REPACK_PAD_EN
    expect_beat("term1", 16'h0000, 16, 1'b0);
    expect_beat("term2", 16'h0000, 8, 1'b1);
`else
    expect_beat("term1", 16'h0000, 0, 1'b1);
`endif
    expect_none("term");
    do_reset();

    // Keep clamping above DATA_W and masking of bits above keep.
    send(16'hABCD, 31, 1'b0);
    send(16'h0003, 1, 1'b1);
    expect_beat("clamp0", 16'hABCD, 16, 1'b0);
`ifdef REPACK_PAD_EN
    expect_beat("clamp1", 16'h0001, 16, 1'b0);
    expect_beat("clamp2", 16'h0000, 8, 1'b1);
`else
    expect_beat("clamp1", 16'h0001, 1, 1'b1);
`endif
    expect_none("clamp");
    do_reset();

    // Output backpressure for 5 cycles while feeding full beats.
    output_tready = 1'b0;
    fork
      begin
        send(16'h1111, 16, 1'b0);
        send(16'h2222, 16, 1'b0);
        send(16'h3333, 16, 1'b0);
        send(16'h4444, 16, 1'b0);
      end
      bp_watch();
    join
    expect_beat("bp0", 16'h1111, 16, 1'b0);
    expect_beat("bp1", 16'h2222, 16, 1'b0);
    expect_beat("bp2", 16'h0033, 8, 1'b1);
    expect_beat("bp3", 16'h4433, 16, 1'b0);
    send(16'h0000, 0, 1'b1);
`ifdef REPACK_PAD_EN
    expect_beat("bp4", 16'h0044, 16, 1'b0);
    expect_beat("bp5", 16'h0000, 8, 1'b1);
`else
    expect_beat("bp4", 16'h0044, 8, 1'b1);
`endif
    expect_none("bp");
    do_reset();

    // Reset after 24 accepted bits; the next 40 bits form a fresh frame.
    send(16'h1111, 16, 1'b0);
    send(16'h00FF, 8, 1'b0);
    @(posedge clk); #1;
    do_reset();
    send(16'hAAAA, 16, 1'b0);
    send(16'hBBBB, 16, 1'b0);
    send(16'h00CC, 8, 1'b0);
    expect_beat("mid0", 16'hAAAA, 16, 1'b0);
    expect_beat("mid1", 16'hBBBB, 16, 1'b0);
    expect_beat("mid2", 16'h00CC, 8, 1'b1);
    expect_none("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
